// File: rtl/demux4_dispatch.sv
// Registered 1-to-4 valid/ready steering block: one input stream fanned out to four
// single-entry output slots. Optional per-channel drain counters under DEMUX4_STATS_EN.
module demux4_dispatch #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic             a_valid,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] c_data,
    output logic [WIDTH-1:0] d_data
`ifdef DEMUX4_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] a_count,
    output logic [CNT_WIDTH-1:0] b_count,
    output logic [CNT_WIDTH-1:0] c_count,
    output logic [CNT_WIDTH-1:0] d_count
`endif
);

    logic [3:0]       vld_p1;
    logic [3:0]       rdy;
    logic [WIDTH-1:0] data_p1 [4];
    logic             accept;

    assign rdy      = {d_ready, c_ready, b_ready, a_ready};
    // Ready looks only at the addressed slot so a stalled consumer blocks only its own traffic.
    assign in_ready = ~vld_p1[in_sel] | rdy[in_sel];
    assign accept   = in_valid & in_ready;

    // Stage p1: one-entry output slots; a load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= '0;
            for (int k = 0; k < 4; k++) begin
                data_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (in_sel == 2'(k))) begin
                    vld_p1[k]  <= 1'b1;
                    data_p1[k] <= in_data;
                end else if (rdy[k]) begin
                    vld_p1[k] <= 1'b0;
                end
            end
        end
    end

    assign a_valid = vld_p1[0];
    assign b_valid = vld_p1[1];
    assign c_valid = vld_p1[2];
    assign d_valid = vld_p1[3];
    assign a_data  = data_p1[0];
    assign b_data  = data_p1[1];
    assign c_data  = data_p1[2];
    assign d_data  = data_p1[3];

`ifdef DEMUX4_STATS_EN
    logic [CNT_WIDTH-1:0] cnt_p1 [4];

    // Counters track completed handoffs to consumers and wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_p1[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (vld_p1[k] && rdy[k]) begin
                    cnt_p1[k] <= cnt_p1[k] + 1'b1;
                end
            end
        end
    end

    assign a_count = cnt_p1[0];
    assign b_count = cnt_p1[1];
    assign c_count = cnt_p1[2];
    assign d_count = cnt_p1[3];
`else
    // Counter width has no effect without the statistics option.
    logic [CNT_WIDTH-1:0] cnt_unused;
    assign cnt_unused = '0;
`endif

endmodule

// File: doc/demux4_dispatch.md
# demux4_dispatch

Registered 1-to-4 steering block: one valid/ready input stream is routed by a 2-bit select to one of four output channels (a, b, c, d), each holding one entry in its own output register. It is the splitting counterpart of the four-input selector used on the datapath: the selector merges four sources onto one bus, and this block fans one producer out to four consumers such as functional units or writeback ports. Each output is independently backpressured, so a stalled consumer blocks only traffic addressed to it.

## Interface
Parameters:
- `WIDTH`, default 32: data width of input and every output channel.
- `CNT_WIDTH`, default 16: width of each transfer counter. Used only with `DEMUX4_STATS_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset is asynchronous and active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in_data`  in  WIDTH  input payload.
- `in_sel`  in  2  destination: 00=a, 01=b, 10=c, 11=d. Meaningful only while `in_valid`=1.
- `a_valid`, `b_valid`, `c_valid`, `d_valid`  out  1 each  output register holds a beat.
- `a_ready`, `b_ready`, `c_ready`, `d_ready`  in  1 each  consumer takes the beat.
- `a_data`, `b_data`, `c_data`, `d_data`  out  WIDTH each  registered payload.
- `a_count`, `b_count`, `c_count`, `d_count`  out  CNT_WIDTH each  completed-transfer counters. These ports exist only with `DEMUX4_STATS_EN`.

## Operation
- Each channel k has a one-entry slot with state EMPTY (k_valid=0) or FULL (k_valid=1).
- Slot drain: the slot drains when k_valid & k_ready.
- Input ready: `in_ready` = ~k_valid[in_sel] | k_ready[in_sel]. This is combinational from `in_sel` and the selected consumer ready. `in_ready` must not depend on `in_valid`.
- Accept: an input beat is accepted when in_valid & in_ready. On acceptance, k_data <= in_data and k_valid <= 1 for k = in_sel.
- Slot transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept to the same slot.
  - FULL→FULL on simultaneous drain and accept to the same slot. The data is replaced and valid stays 1 with no bubble.
- A drain on slot j and an accept to slot k≠j in the same cycle are both performed independently.
- A FULL slot with k_ready=0 holds k_data stable. k_valid must not drop until the beat drains.
- Ordering: beats to the same channel leave in acceptance order. There is no ordering guarantee across channels.
- `k_data` is don't-care-free: it retains its last value after a drain and is not cleared.
- No beat is ever dropped or duplicated.

## Timing
- Latency is 1 cycle. A beat accepted at edge T appears as k_valid=1 with k_data from cycle T+1.
- Sustained throughput is 1 beat/cycle to a single channel while its consumer holds ready=1.
- Reset values: all k_valid=0, all k_data=0, all k_count=0. `in_ready`=1 during and after reset, because all slots are empty.
- Reset mid-operation: asserting `rst_n`=0 clears all slots immediately, regardless of the clock. Beats held in slots are discarded. The first accept is possible on the first rising edge after deassertion.
- `in_sel` changing while `in_valid`=1 and `in_ready`=0 is permitted. `in_ready` re-evaluates against the new target.

## Configuration
- `DEMUX4_STATS_EN` defined:
  - The four `k_count` ports and counters are compiled in.
  - k_count increments by 1 on each drain of channel k (k_valid & k_ready).
  - The counter wraps from 2^CNT_WIDTH−1 to 0.
  - Accepts do not count.
- `DEMUX4_STATS_EN` undefined: the counter ports and logic are absent. Steering behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and in_sel=10 → all k_valid=0, all k_data=0, in_ready=1, and no slot loads. Release reset; the first edge with in_data=0x0000_00C3 loads c_data=0x0000_00C3 and c_valid=1 on the next cycle.
- Round-robin steering: all consumers ready=1; send 0x11, 0x22, 0x33, 0x44 with in_sel=00, 01, 10, 11 on consecutive cycles → a, b, c, d each pulse valid for one cycle with the matching data, one cycle after each accept.
- Backpressure isolation:
  - Set b_ready=0 and load 0xBB into b. A second beat to b then sees in_ready=0, and b_data stays 0xBB.
  - Beats to a and d are still accepted in the same cycles.
  - When b_ready=1, 0xBB drains and the pending beat is accepted in the same cycle.
- Same-slot drain+accept: d FULL with 0x1, d_ready=1, and in_valid=1, in_sel=11, in_data=0x2 → d_valid stays 1, and d_data=0x2 on the next cycle.
- Streaming: 8 back-to-back beats 0..7 to channel a with a_ready=1 → a_data sequence 0..7 on consecutive cycles, in_ready=1 throughout.
- With `DEMUX4_STATS_EN` and CNT_WIDTH=4: 17 drains on channel c → c_count=1 after wrap, and a_count, b_count, d_count remain 0. Assert rst_n=0 mid-stream → all counts=0.
